mash_dsm: RTL and testbench

MASH_DSM -- requirements
Module: mash_dsm

---
 rtl/mash_dsm_pkg.sv | 14 +
 rtl/mash_dsm_stage.sv | 33 +++
 rtl/mash_dsm.sv | 151 +++++++++++++++
 tb/tb_mash_dsm.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mash_dsm_pkg.sv
// Shared types and constants for the time-shared MASH delta-sigma modulator.
package mash_dsm_pkg;

  localparam int OUT_W = 4;
  localparam logic [OUT_W-1:0] OUT_OFFSET = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic signed [1:0] qlevel_t;

endpackage

// File: rtl/mash_dsm_stage.sv
// One first-order error-feedback stage: v = acc + u, 3-level quantise, fold back by FS.
module mash_dsm_stage
  import mash_dsm_pkg::*;
#(
  parameter int DIN_W = 16,
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] u,
  output qlevel_t                 q,
  output logic signed [ACC_W-1:0] acc_next
);

  localparam logic signed [ACC_W-1:0] FS   = ACC_W'(longint'(1) <<< (DIN_W - 1));
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(longint'(1) <<< (DIN_W - 2));

  logic signed [ACC_W-1:0] v;

  always_comb begin
    v = acc + u;
    if (v >= HALF) begin
      q        = 2'sd1;
      acc_next = v - FS;
    end else if (v < -HALF) begin
      q        = -2'sd1;
      acc_next = v + FS;
    end else begin
      q        = '0;
      acc_next = v;
    end
  end

endmodule

// File: rtl/mash_dsm.sv
// Multi-channel MASH 1-1 / 1-1-1 modulator sharing one stage chain across channels.
// Optional LFSR dither on the last stage is enabled by defining MASH_DSM_DITHER_EN.
module mash_dsm
  import mash_dsm_pkg::*;
#(
  parameter int DIN_W  = 16,
  parameter int ACC_W  = 24,
  parameter int CH     = 2,
  parameter int STAGES = 3
) (
  input  logic                ACLK,
  input  logic                ARST,
  input  logic [CH*DIN_W-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [CH*OUT_W-1:0] dout,
  output logic                dout_valid
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CH - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [CH*DIN_W-1:0]     din_lat;
  logic signed [ACC_W-1:0] acc_r   [STAGES][SLOTS];
  qlevel_t                 q2z1_r  [SLOTS];
  qlevel_t                 q3z1_r  [SLOTS];
  qlevel_t                 q3z2_r  [SLOTS];
  logic [OUT_W-1:0]        code_buf[SLOTS];
  logic [CH*OUT_W-1:0]     dout_r;
  logic                    dout_valid_r;

  logic signed [DIN_W-1:0] sample;
  logic signed [ACC_W-1:0] dither_u;
  logic signed [ACC_W-1:0] acc_nxt [STAGES];
  qlevel_t                 q1_cur, q2_cur, q3_cur;
  logic signed [3:0]       y;
  logic [OUT_W-1:0]        code;

  assign sample = din_lat[int'(idx)*DIN_W +: DIN_W];

`ifdef MASH_DSM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      lfsr <= 16'hACE1;
    end else if (state == RUN) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign dither_u = {{(ACC_W-1){1'b0}}, lfsr[0]};
`else
  assign dither_u = '0;
`endif

  // Chain links use each block's own nets so the stage-to-stage path stays acyclic.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [ACC_W-1:0] u;
    logic signed [ACC_W-1:0] acc_n;
    qlevel_t                 q;

    if (k == 0) begin : g_in
      assign u = ACC_W'(sample);
    end else if (k == STAGES - 1) begin : g_last
      assign u = -g_stage[k-1].acc_n + dither_u;
    end else begin : g_mid
      assign u = -g_stage[k-1].acc_n;
    end

    mash_dsm_stage #(
      .DIN_W (DIN_W),
      .ACC_W (ACC_W)
    ) u_stage (
      .acc      (acc_r[k][idx]),
      .u        (u),
      .q        (q),
      .acc_next (acc_n)
    );

    assign acc_nxt[k] = acc_n;
  end

  assign q1_cur = g_stage[0].q;
  assign q2_cur = g_stage[1].q;

  if (STAGES == 3) begin : g_q3
    assign q3_cur = g_stage[2].q;
  end else begin : g_no_q3
    assign q3_cur = '0;
  end

  always_comb begin
    y = 4'(q1_cur) + 4'(q2_cur) - 4'(q2z1_r[idx])
      + 4'(q3_cur) - 4'(q3z1_r[idx]) - 4'(q3z1_r[idx]) + 4'(q3z2_r[idx]);
    code = $unsigned(y) + OUT_OFFSET;
  end

  // Codes are staged per channel and published together so dout only moves with dout_valid.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state        <= IDLE;
      idx          <= '0;
      din_lat      <= '0;
      dout_r       <= {CH{OUT_OFFSET}};
      dout_valid_r <= 1'b0;
      for (int unsigned s = 0; s < SLOTS; s++) begin
        for (int unsigned k = 0; k < STAGES; k++) acc_r[k][s] <= '0;
        q2z1_r[s]   <= '0;
        q3z1_r[s]   <= '0;
        q3z2_r[s]   <= '0;
        code_buf[s] <= OUT_OFFSET;
      end
    end else begin
      dout_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            din_lat <= din;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < STAGES; k++) acc_r[k][idx] <= acc_nxt[k];
          q2z1_r[idx]   <= q2_cur;
          q3z2_r[idx]   <= q3z1_r[idx];
          q3z1_r[idx]   <= q3_cur;
          code_buf[idx] <= code;
          idx           <= idx + 1'b1;
          if (idx == LAST) begin
            state        <= IDLE;
            dout_valid_r <= 1'b1;
            for (int unsigned c = 0; c < CH; c++) begin
              dout_r[c*OUT_W +: OUT_W] <= (c == unsigned'(CH - 1)) ? code : code_buf[c];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign din_ready  = (state == IDLE);
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_mash_dsm.sv
// Bench for mash_dsm: three configurations (2ch/1-1-1, 1ch/1-1, 4ch/1-1-1) against an integer model.
module tb_mash_dsm;

  localparam longint FSV = 32768;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        rst_ab = 1'b1, rst_c = 1'b1;
  logic [31:0] din_a = '0;
  logic [15:0] din_b = '0;
  logic [63:0] din_c = '0;
  logic        vin_a = 1'b0, vin_b = 1'b0, vin_c = 1'b0;
  logic        rdy_a, rdy_b, rdy_c;
  logic [7:0]  dout_a;
  logic [3:0]  dout_b;
  logic [15:0] dout_c;
  logic        vout_a, vout_b, vout_c;

  int n_checks = 0;
  int n_err    = 0;

  mash_dsm u_a (
    .ACLK(ACLK), .ARST(rst_ab), .din(din_a), .din_valid(vin_a), .din_ready(rdy_a),
    .dout(dout_a), .dout_valid(vout_a)
  );

  mash_dsm #(.CH(1), .STAGES(2)) u_b (
    .ACLK(ACLK), .ARST(rst_ab), .din(din_b), .din_valid(vin_b), .din_ready(rdy_b),
    .dout(dout_b), .dout_valid(vout_b)
  );

  mash_dsm #(.CH(4), .STAGES(3)) u_c (
    .ACLK(ACLK), .ARST(rst_c), .din(din_c), .din_valid(vin_c), .din_ready(rdy_c),
    .dout(dout_c), .dout_valid(vout_c)
  );

  typedef struct {
    longint a1, a2, a3;
    int     q2z1, q3z1, q3z2;
  } mstate_t;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp;
  } vec_t;

  mstate_t ms_a[2];
  mstate_t ms_b[1];
  mstate_t ms_c[4];

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected within %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int quant(input longint v);
    if (v >= FSV / 2) return 1;
    if (v < -FSV / 2) return -1;
    return 0;
  endfunction

  function automatic int mash_ref(inout mstate_t s, input int din, input int stages);
    int q1, q2, q3, y;
    longint v;
    v = s.a1 + din;  q1 = quant(v); s.a1 = v - q1 * FSV;
    v = -s.a1 + s.a2; q2 = quant(v); s.a2 = v - q2 * FSV;
    y = q1 + q2 - s.q2z1;
    s.q2z1 = q2;
    if (stages == 3) begin
      v = -s.a2 + s.a3; q3 = quant(v); s.a3 = v - q3 * FSV;
      y += q3 - 2 * s.q3z1 + s.q3z2;
      s.q3z2 = s.q3z1;
      s.q3z1 = q3;
    end
    return y + 8;
  endfunction

  function automatic int nch(input int inst);
    return (inst == 0) ? 2 : (inst == 1) ? 1 : 4;
  endfunction

  function automatic logic [15:0] model_set(input int inst, input logic [63:0] d);
    logic [15:0] r;
    mstate_t s;
    int code;
    r = '0;
    for (int c = 0; c < nch(inst); c++) begin
      case (inst)
        0:       s = ms_a[c];
        1:       s = ms_b[c];
        default: s = ms_c[c];
      endcase
      code = mash_ref(s, int'($signed(d[c*16 +: 16])), (inst == 1) ? 2 : 3);
      case (inst)
        0:       ms_a[c] = s;
        1:       ms_b[c] = s;
        default: ms_c[c] = s;
      endcase
      r[c*4 +: 4] = 4'(code);
    end
    return r;
  endfunction

  function automatic void model_reset(input bit ab, input bit c);
    if (ab) begin
      foreach (ms_a[i]) ms_a[i] = '{default: 0};
      foreach (ms_b[i]) ms_b[i] = '{default: 0};
    end
    if (c) foreach (ms_c[i]) ms_c[i] = '{default: 0};
  endfunction

  function automatic logic rdy(input int inst);
    return (inst == 0) ? rdy_a : (inst == 1) ? rdy_b : rdy_c;
  endfunction

  function automatic logic vout(input int inst);
    return (inst == 0) ? vout_a : (inst == 1) ? vout_b : vout_c;
  endfunction

  function automatic logic [15:0] dout_of(input int inst);
    return (inst == 0) ? {8'h00, dout_a} : (inst == 1) ? {12'h000, dout_b} : dout_c;
  endfunction

  task automatic drive(input int inst, input logic [63:0] d, input logic v);
    case (inst)
      0:       begin din_a = d[31:0]; vin_a = v; end
      1:       begin din_b = d[15:0]; vin_b = v; end
      default: begin din_c = d;       vin_c = v; end
    endcase
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] bnd[7];
    bnd = '{16'h8000, 16'h7FFF, 16'h4000, 16'hC000, 16'h3FFF, 16'hBFFF, 16'h0000};
    if ($urandom_range(0, 3) == 0) return bnd[$urandom_range(0, 6)];
    return 16'($urandom);
  endfunction

  function automatic logic [63:0] rnd_set();
    return {rnd16(), rnd16(), rnd16(), rnd16()};
  endfunction

  task automatic pulse_reset(input bit ab, input bit c);
    @(negedge ACLK);
    if (ab) rst_ab = 1'b1;
    if (c)  rst_c  = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    model_reset(ab, c);
  endtask

  // Offer one set, scramble din while RUN, then wait (bounded) for dout_valid.
  task automatic xfer(input int inst, input logic [63:0] d, output logic [15:0] codes);
    int n;
    bit seen, stable;
    logic [15:0] held;
    n = 0;
    @(negedge ACLK);
    while (!rdy(inst) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk_eq("ready_before_offer", rdy(inst), 1);
    drive(inst, d, 1'b1);
    @(negedge ACLK);
    drive(inst, {$urandom, $urandom}, 1'b0);
    held   = dout_of(inst);
    seen   = 1'b0;
    stable = 1'b1;
    n      = 0;
    while (!seen && n < 20) begin
      @(negedge ACLK);
      n++;
      if (vout(inst)) seen = 1'b1;
      else if (dout_of(inst) !== held) stable = 1'b0;
    end
    chk_eq("accept_to_valid_latency", seen ? n : -1, nch(inst));
    chk_eq("dout_stable_between_pulses", stable, 1);
    codes = dout_of(inst);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] got, exp, d16;
    logic [63:0] d;
    logic [7:0]  first_run[256];
    int          sum0, sum1, n, first;
    bit          ok;

    vecs[0] = '{din: {16'h7FFF, 16'h8000}, exp: 8'h97};
    vecs[1] = '{din: {16'h8000, 16'h7FFF}, exp: 8'h79};
    vecs[2] = '{din: {16'h4000, 16'h0000}, exp: 8'hB8};
    vecs[3] = '{din: {16'hC000, 16'h3FFF}, exp: 8'hA8};
    vecs[4] = '{din: {16'h0000, 16'hBFFF}, exp: 8'h87};
    vecs[5] = '{din: {16'h0000, 16'h0000}, exp: 8'h88};

    // Reset held, then released with no offers.
    repeat (3) @(negedge ACLK);
    chk_eq("rst_dout_a", dout_a, 8'h88);
    chk_eq("rst_dout_b", dout_b, 4'h8);
    chk_eq("rst_dout_c", dout_c, 16'h8888);
    chk_eq("rst_valid_a", vout_a, 0);
    chk_eq("rst_ready_a", rdy_a, 1);
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    model_reset(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      chk_eq("idle_hold_a", {vout_a, rdy_a, dout_a}, {1'b0, 1'b1, 8'h88});
    end

    // First set after reset, hand-computed codes.
    foreach (vecs[i]) begin
      pulse_reset(1'b1, 1'b0);
      xfer(0, {32'h0, vecs[i].din}, got);
      chk_eq("vec_first_set", got[7:0], vecs[i].exp);
    end

    pulse_reset(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      xfer(0, 64'h0, got);
      chk_eq("zero_input_code", got[7:0], 8'h88);
    end

    pulse_reset(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      d   = rnd_set();
      exp = model_set(0, d);
      xfer(0, d, got);
      chk_eq("rand_a_codes", got[7:0], exp[7:0]);
    end

    // Single channel MASH 1-1 at FS/2.
    pulse_reset(1'b1, 1'b0);
    sum0 = 0;
    for (int i = 0; i < 256; i++) begin
      exp = model_set(1, 64'h4000);
      xfer(1, 64'h4000, got);
      if (i == 0) chk_eq("b_first_code", got[3:0], exp[3:0]);
      else        chk_eq("b_model_code", got[3:0], exp[3:0]);
      chk_rng("b_code_range", got[3:0], 5, 11);
      sum0 += int'(got[3:0]) - 8;
    end
    chk_rng("b_sum_half_scale", sum0, 126, 130);

    // Full-scale extremes, then swapped channels.
    pulse_reset(1'b1, 1'b0);
    sum0 = 0;
    sum1 = 0;
    for (int i = 0; i < 256; i++) begin
      xfer(0, {32'h0, 16'h7FFF, 16'h8000}, got);
      first_run[i] = got[7:0];
      chk_rng("fs_code_ch0", got[3:0], 1, 15);
      chk_rng("fs_code_ch1", got[7:4], 1, 15);
      sum0 += int'(got[3:0]) - 8;
      sum1 += int'(got[7:4]) - 8;
    end
    chk_rng("fs_sum_ch0_negative", sum0, -260, -252);
    chk_rng("fs_sum_ch1_positive", sum1, 252, 260);
    pulse_reset(1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      xfer(0, {32'h0, 16'h8000, 16'h7FFF}, got);
      chk_eq("swap_symmetry", got[7:0], {first_run[i][3:0], first_run[i][7:4]});
    end

    // din_valid held high: ready 1,0,0 and dout_valid on every third cycle.
    pulse_reset(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      chk_eq("hs_ready", rdy_a, (i % 3 == 0) ? 1 : 0);
      chk_eq("hs_valid", vout_a, (i % 3 == 0 && i > 0) ? 1 : 0);
      if (i == 0) begin
        din_a = $urandom;
        vin_a = 1'b1;
      end
    end
    vin_a = 1'b0;

    // Four channels: warm up, abort on the second RUN cycle, restart cold.
    pulse_reset(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      d   = rnd_set();
      exp = model_set(2, d);
      xfer(2, d, got);
      chk_eq("rand_c_codes", got, exp);
    end
    @(negedge ACLK);
    n = 0;
    while (!rdy_c && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk_eq("abort_ready_before_offer", rdy_c, 1);
    din_c = rnd_set();
    vin_c = 1'b1;
    @(negedge ACLK);
    vin_c = 1'b0;
    @(negedge ACLK);
    rst_c = 1'b1;
    #1;
    chk_eq("abort_async_ready", rdy_c, 1);
    chk_eq("abort_async_dout", dout_c, 16'h8888);
    @(negedge ACLK);
    chk_eq("abort_next_ready", rdy_c, 1);
    chk_eq("abort_next_dout", dout_c, 16'h8888);
    chk_eq("abort_next_valid", vout_c, 0);
    rst_c = 1'b0;
    model_reset(1'b0, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      if (vout_c) ok = 1'b0;
    end
    chk_eq("abort_no_valid", ok, 1);
    first = 1;
    for (int i = 0; i < 5; i++) begin
      d   = rnd_set();
      exp = model_set(2, d);
      xfer(2, d, got);
      chk_eq(first ? "cold_after_abort_first" : "cold_after_abort", got, exp);
      first = 0;
    end
    d16 = 16'h4000;
    d   = {4{d16}};
    exp = model_set(2, d);
    xfer(2, d, got);
    chk_eq("c_half_scale_all", got, exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
